l2_refill_responder: RTL and testbench

L2_REFILL_RESPONDER -- requirements
Module: l2_refill_responder

---
 rtl/l2_refill_responder.sv | 113 +++++++++++
 tb/tb_l2_refill_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2_refill_responder.sv
// L2-to-L1 instruction refill responder: accepts one I-cache miss, fetches the
// 512-bit line as four 128-bit beats, then strobes it into the L1 with a victim way.
module l2_refill_responder #(
  parameter int NBEATS = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         miss_req,
  input  logic [31:0]  miss_addr,
  output logic         miss_ready,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ack,
  input  logic         mem_rvalid,
  input  logic [127:0] mem_rdata,
  output logic [511:0] read_data_L2_L1,
  output logic         refill,
  output logic [1:0]   index_C_L1,
  output logic         way,
  output logic [1:0]   state_dbg_o
);

  // Handshakes: a miss is taken on any rising edge where miss_req=1 and
  // miss_ready=1; mem_req stays high until the edge that samples mem_ack=1;
  // each edge with mem_rvalid=1 in FILL consumes exactly one beat.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] LAST_BEAT = 2'(NBEATS - 1);

  state_t       state_q;
  logic [1:0]   cnt_q;
  logic [511:0] line_q;
  logic [3:0]   victim_q;
  logic         miss_ready_q;
  logic         mem_req_q;
  logic [31:0]  mem_addr_q;
  logic         refill_q;
  logic [511:0] rdata_q;
  logic [1:0]   index_q;
  logic         way_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      line_q       <= '0;
      victim_q     <= 4'd0;
      miss_ready_q <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'd0;
      refill_q     <= 1'b0;
      rdata_q      <= '0;
      index_q      <= 2'd0;
      way_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_req) begin
            mem_addr_q   <= {miss_addr[31:6], 6'b0};
            mem_req_q    <= 1'b1;
            miss_ready_q <= 1'b0;
            state_q      <= REQ;
          end
        end
        REQ: begin
          // A beat arriving with the ack is deliberately dropped.
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            cnt_q     <= 2'd0;
            state_q   <= FILL;
          end
        end
        FILL: begin
          if (mem_rvalid) begin
            line_q[{cnt_q, 7'd0} +: 128] <= mem_rdata;
            cnt_q                        <= cnt_q + 2'd1;
            if (cnt_q == LAST_BEAT) begin
              // Final beat goes straight to the output so refill can fire next cycle.
              rdata_q  <= {mem_rdata, line_q[383:0]};
              index_q  <= mem_addr_q[7:6];
              way_q    <= victim_q[mem_addr_q[7:6]];
              refill_q <= 1'b1;
              state_q  <= RESP;
            end
          end
        end
        RESP: begin
          refill_q          <= 1'b0;
          victim_q[index_q] <= ~victim_q[index_q];
          miss_ready_q      <= 1'b1;
          state_q           <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miss_ready      = miss_ready_q;
  assign mem_req         = mem_req_q;
  assign mem_addr        = mem_addr_q;
  assign refill          = refill_q;
  assign read_data_L2_L1 = rdata_q;
  assign index_C_L1      = index_q;
  assign way             = way_q;
  assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_l2_refill_responder.sv
// Directed vector bench for l2_refill_responder: a table of miss transactions
// plus a hand-written reset-during-fill sequence.
module tb_l2_refill_responder;

  logic         clk = 1'b0;
  logic         nrst;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         miss_ready;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic         mem_rvalid;
  logic [127:0] mem_rdata;
  logic [511:0] read_data_L2_L1;
  logic         refill;
  logic [1:0]   index_C_L1;
  logic         way;
  logic [1:0]   state_dbg_o;

  l2_refill_responder #(.NBEATS(4)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .miss_req        (miss_req),
    .miss_addr       (miss_addr),
    .miss_ready      (miss_ready),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .read_data_L2_L1 (read_data_L2_L1),
    .refill          (refill),
    .index_C_L1      (index_C_L1),
    .way             (way),
    .state_dbg_o     (state_dbg_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ack_dly;
    logic [15:0] pat;
    int          plen;
    logic        noise;
    logic [31:0] exp_maddr;
    logic [1:0]  exp_idx;
    logic        exp_way;
  } vec_t;

  vec_t         vecs[7];
  int           n_vec  = 0;
  int           n_fail = 0;
  int           refill_seen = 0;
  logic [511:0] last_line;

  always @(negedge clk) if (refill) refill_seen++;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 512'(miss_ready), 512'd1);
    check({tag, "_mem_req"}, 512'(mem_req), 512'd0);
    check({tag, "_mem_addr"}, 512'(mem_addr), 512'd0);
    check({tag, "_refill"}, 512'(refill), 512'd0);
    check({tag, "_rdata"}, read_data_L2_L1, 512'd0);
    check({tag, "_index"}, 512'(index_C_L1), 512'd0);
    check({tag, "_way"}, 512'(way), 512'd0);
    check({tag, "_state"}, 512'(state_dbg_o), 512'd0);
  endtask

  function automatic logic [127:0] beat_of(input int v, input int b);
    beat_of = {4{8'(v), 8'(b), 16'hB00B}};
  endfunction

  // Drives one complete miss; starts and ends on a negedge, ends in the cycle after RESP.
  task automatic run_vec(input int v);
    vec_t         t;
    int           nb;
    int           r0;
    logic [511:0] exp_line;
    t  = vecs[v];
    nb = 0;
    r0 = refill_seen;
    exp_line = {beat_of(v, 3), beat_of(v, 2), beat_of(v, 1), beat_of(v, 0)};
    check($sformatf("v%0d_ready_in", v), 512'(miss_ready), 512'd1);
    miss_req  = 1'b1;
    miss_addr = t.addr;
    if (t.noise) begin
      mem_rvalid = 1'b1;
      mem_rdata  = '1;
    end
    @(negedge clk);
    miss_req   = 1'b0;
    miss_addr  = 32'h0;
    mem_rvalid = 1'b0;
    check($sformatf("v%0d_ready_busy", v), 512'(miss_ready), 512'd0);
    for (int j = 0; j < t.ack_dly; j++) begin
      check($sformatf("v%0d_req_wait%0d", v, j), 512'(mem_req), 512'd1);
      check($sformatf("v%0d_addr_wait%0d", v, j), 512'(mem_addr), 512'(t.exp_maddr));
      @(negedge clk);
    end
    check($sformatf("v%0d_req_ack", v), 512'(mem_req), 512'd1);
    check($sformatf("v%0d_addr_ack", v), 512'(mem_addr), 512'(t.exp_maddr));
    mem_ack = 1'b1;
    if (t.noise) begin
      mem_rvalid = 1'b1;
      mem_rdata  = {4{32'hDEAD_DEAD}};
    end
    @(negedge clk);
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    check($sformatf("v%0d_req_drop", v), 512'(mem_req), 512'd0);
    for (int j = 0; j < t.plen; j++) begin
      if (t.pat[j]) begin
        mem_rvalid = 1'b1;
        mem_rdata  = beat_of(v, nb);
        nb++;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = {4{32'hBAD0_BAD0}};
        if (t.noise) begin
          miss_req  = 1'b1;
          miss_addr = 32'hFFFF_FFC0;
        end
      end
      check($sformatf("v%0d_no_early_refill%0d", v, j), 512'(refill), 512'd0);
      @(negedge clk);
      miss_req = 1'b0;
    end
    mem_rvalid = 1'b0;
    check($sformatf("v%0d_refill", v), 512'(refill), 512'd1);
    check($sformatf("v%0d_line", v), read_data_L2_L1, exp_line);
    check($sformatf("v%0d_index", v), 512'(index_C_L1), 512'(t.exp_idx));
    check($sformatf("v%0d_way", v), 512'(way), 512'(t.exp_way));
    @(negedge clk);
    check($sformatf("v%0d_refill_off", v), 512'(refill), 512'd0);
    check($sformatf("v%0d_ready_after", v), 512'(miss_ready), 512'd1);
    check($sformatf("v%0d_line_hold", v), read_data_L2_L1, exp_line);
    check($sformatf("v%0d_one_pulse", v), 512'(refill_seen - r0), 512'd1);
    last_line = exp_line;
  endtask

  initial begin
    int r0;
    //            addr          dly  pattern      len noise exp_maddr     idx    way
    vecs[0] = '{32'h0000_0040, 0, 16'h000F, 4, 1'b0, 32'h0000_0040, 2'd1, 1'b0};
    vecs[1] = '{32'h0000_1A84, 0, 16'h000F, 4, 1'b0, 32'h0000_1A80, 2'd2, 1'b0};
    vecs[2] = '{32'h0000_2050, 0, 16'h000F, 4, 1'b0, 32'h0000_2040, 2'd1, 1'b1};
    vecs[3] = '{32'hDEAD_BEFC, 0, 16'h0059, 7, 1'b0, 32'hDEAD_BEC0, 2'd3, 1'b0};
    vecs[4] = '{32'h1234_5678, 5, 16'h000F, 4, 1'b0, 32'h1234_5640, 2'd1, 1'b0};
    vecs[5] = '{32'h0000_0184, 0, 16'h0055, 7, 1'b1, 32'h0000_0180, 2'd2, 1'b1};
    vecs[6] = '{32'h0000_00C4, 0, 16'h000F, 4, 1'b0, 32'h0000_00C0, 2'd3, 1'b0};

    nrst       = 1'b0;
    miss_req   = 1'b0;
    miss_addr  = 32'h0;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst_held");
    nrst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_rel");

    for (int v = 0; v < 6; v++) run_vec(v);

    // Abort a fill after two beats with an asynchronous reset.
    r0        = refill_seen;
    miss_req  = 1'b1;
    miss_addr = 32'h0000_00C4;
    @(negedge clk);
    miss_req = 1'b0;
    mem_ack  = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = {4{32'hABCD_0000 + 32'(b)}};
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    check("abort_in_fill", 512'(state_dbg_o), 512'd2);
    #2 nrst = 1'b0;
    #1;
    check_reset_outputs("abort_async");
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("abort_no_refill", 512'(refill_seen - r0), 512'd0);
    check_reset_outputs("abort_rel");

    run_vec(6);

    repeat (3) @(negedge clk);
    check("hold_line", read_data_L2_L1, last_line);
    check("hold_index", 512'(index_C_L1), 512'd3);
    check("hold_way", 512'(way), 512'd0);
    check("hold_idle", 512'(state_dbg_o), 512'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end

endmodule
